// File: rtl/apb_requester.sv
// APB requester: one command becomes one SETUP plus ACCESS transfer; rsp_valid comes one cycle after PREADY or timeout (3 cycles minimum).
// Backpressure: cmd_ready is high only in IDLE; the response is a single-cycle pulse with no backpressure.
module apb_requester #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   input  logic [DATA_WIDTH-1:0] PRDATA
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic [7:0]            r_cnt;
   logic                  r_rdy;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_rsp_to;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_tmo;

   assign w_accept = cmd_valid & r_rdy;
   assign w_done   = (r_state == S_ACCESS) & PREADY;
   // PREADY wins over a coincident timeout
   assign w_tmo    = (r_state == S_ACCESS) & ~PREADY & (r_cnt == TO_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_SETUP;
         S_SETUP:  w_next = S_ACCESS;
         S_ACCESS: if (w_done || w_tmo) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_rdy       <= 1'b0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_to    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_rdy       <= (w_next == S_IDLE);
         r_rsp_valid <= w_done | w_tmo;
         if (w_accept) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_wdata;
         end
         if (r_state == S_SETUP || w_done || w_tmo)
            r_cnt <= 8'd0;
         else if (r_state == S_ACCESS)
            r_cnt <= r_cnt + 8'd1;
         // Response fields hold between pulses; rsp_valid alone qualifies them
         if (w_done) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_rsp_to    <= 1'b0;
         end else if (w_tmo) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_to    <= 1'b1;
         end
      end
   end

   assign cmd_ready   = r_rdy;
   assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign PENABLE     = (r_state == S_ACCESS);
   assign PADDR       = r_paddr;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_to;

endmodule
